// File: rtl/seg_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg_scanner                                                |
// | Description : Time-multiplexed scan controller for a 4-digit common-     |
// |               anode seven-segment display. Emits the current digit's     |
// |               nibble with active-low digit-select and decimal-point      |
// |               drives. New display values are committed only at frame     |
// |               boundaries. Optional leading-zero blanking is enabled by   |
// |               defining SEG_SCAN_LZB_EN.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seg_scanner #(
  parameter int DIV   = 50000,
  parameter int GUARD = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_blank,
  output logic [3:0]  o_nibble,
  output logic [3:0]  o_dig_n,
  output logic        o_dp_n,
  output logic        o_busy,
  output logic        o_frame_tick
);

  localparam int                 c_CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV - 1);
  localparam logic [c_CNT_W-1:0] c_GUARD    = c_CNT_W'(GUARD);

  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic [15:0]        r_pval;
  logic [3:0]         r_pdp;
  logic [3:0]         r_pblank;
  logic               r_busy;
  logic [15:0]        r_dval;
  logic [3:0]         r_ddp;
  logic [3:0]         r_dblank;

  logic               w_slot_end;
  logic               w_boundary;
  logic [3:0]         w_lzb;
  logic               w_dark;
  logic               w_on;

  assign w_slot_end = (r_cnt == c_CNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == 2'd3);

  // Slot counter and digit index; index advances on the last cycle of a slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  // Pending capture on load and tear-free commit into the display registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pval   <= 16'h0000;
      r_pdp    <= 4'h0;
      r_pblank <= 4'h0;
      r_busy   <= 1'b0;
      r_dval   <= 16'h0000;
      r_ddp    <= 4'h0;
      r_dblank <= 4'hF;
    end else begin
      if (i_load) begin
        r_pval   <= i_value;
        r_pdp    <= i_dp;
        r_pblank <= i_blank;
        r_busy   <= 1'b1;
      end
      if (w_boundary) begin
        // A load landing on the boundary bypasses the pending stage entirely.
        if (i_load) begin
          r_dval   <= i_value;
          r_ddp    <= i_dp;
          r_dblank <= i_blank;
          r_busy   <= 1'b0;
        end else if (r_busy) begin
          r_dval   <= r_pval;
          r_ddp    <= r_pdp;
          r_dblank <= r_pblank;
          r_busy   <= 1'b0;
        end
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Digit 0 always shows, so a zero value still displays a single 0.
  assign w_lzb[0] = 1'b0;
  generate
    for (genvar k = 1; k < 4; k++) begin : g_lzb
      assign w_lzb[k] = (r_dval[15:4*k] == '0) && !r_ddp[k];
    end
  endgenerate
`else
  assign w_lzb = 4'b0000;
`endif

  assign w_dark = r_dblank[r_idx] | w_lzb[r_idx];
  // Guard interval at the start of each slot keeps all digits off to avoid ghosting.
  assign w_on   = (r_cnt >= c_GUARD) && !w_dark;

  assign o_nibble     = r_dval[{r_idx, 2'b00} +: 4];
  assign o_dig_n      = w_on ? ~(4'b0001 << r_idx) : 4'hF;
  assign o_dp_n       = ~(r_ddp[r_idx] & w_on);
  assign o_busy       = r_busy;
  assign o_frame_tick = w_boundary;

endmodule
`default_nettype wire
